// File: rtl/reg_map_table.sv
// reg_map_table
// -----------------------------------------------------------------------------
// Architectural-to-physical register map for the rename stage.
//
// Holds the current arch->phys mapping, a ready bit per physical register and
// a small ring of whole-map checkpoints used for branch speculation.
//
// Ports
//   CLK, RST                          clock, synchronous active-high reset
//   source_arch_reg_tag_A/B           source operand arch regs (lookup)
//   source_phys_reg_tag_A/B           current mapping of each source
//   source_ready_A/B                  readiness of that mapping (with a
//                                     same-cycle writeback bypass)
//   rename_valid / rename_dest_*      rename one destination; the new phys
//                                     tag comes from the free list
//   rename_old_dest_phys_reg_tag      mapping being replaced, for the ROB
//   complete_valid / _phys_reg_tag    writeback, sets a ready bit
//   revert_valid / revert_*           ROB rollback of one mapping
//   save_checkpoint_*                 save the map into the tail column
//   checkpoint_full                   the tail column is still in use
//   restore_checkpoint_*              branch resolution: restore the map on a
//                                     mispredict, release the column otherwise
//   restore_checkpoint_success        column valid and ROB index matched
//
// Handshake: every *_valid input is a single-cycle request that the block
// always accepts in the cycle it is high; there is no ready/back-pressure.
// Upstream stalls dispatch on checkpoint_full.
//
// Priority within a cycle: RST > failed restore > revert > rename/save.
// Complete is always applied, release may coincide with anything except a
// failed restore, and a rename ready-clear beats a same-tag complete.
// -----------------------------------------------------------------------------
module reg_map_table #(
    parameter int NUM_ARCH_REGS      = 32,
    parameter int NUM_PHYS_REGS      = 64,
    parameter int CHECKPOINT_COLUMNS = 4,
    parameter int ROB_DEPTH          = 16,
    parameter int ARCH_W             = $clog2(NUM_ARCH_REGS),
    parameter int PHYS_W             = $clog2(NUM_PHYS_REGS),
    parameter int COL_W              = $clog2(CHECKPOINT_COLUMNS),
    parameter int ROB_W              = $clog2(ROB_DEPTH)
) (
    input  logic              CLK,
    input  logic              RST,

    input  logic [ARCH_W-1:0] source_arch_reg_tag_A,
    output logic [PHYS_W-1:0] source_phys_reg_tag_A,
    output logic              source_ready_A,
    input  logic [ARCH_W-1:0] source_arch_reg_tag_B,
    output logic [PHYS_W-1:0] source_phys_reg_tag_B,
    output logic              source_ready_B,

    input  logic              rename_valid,
    input  logic [ARCH_W-1:0] rename_dest_arch_reg_tag,
    input  logic [PHYS_W-1:0] rename_dest_phys_reg_tag,
    output logic [PHYS_W-1:0] rename_old_dest_phys_reg_tag,

    input  logic              complete_valid,
    input  logic [PHYS_W-1:0] complete_phys_reg_tag,

    input  logic              revert_valid,
    input  logic [ARCH_W-1:0] revert_dest_arch_reg_tag,
    input  logic [PHYS_W-1:0] revert_safe_dest_phys_reg_tag,

    input  logic              save_checkpoint_valid,
    input  logic [ROB_W-1:0]  save_checkpoint_ROB_index,
    output logic [COL_W-1:0]  save_checkpoint_column,
    output logic              checkpoint_full,

    input  logic              restore_checkpoint_valid,
    input  logic              restore_checkpoint_speculate_failed,
    input  logic [ROB_W-1:0]  restore_checkpoint_ROB_index,
    input  logic [COL_W-1:0]  restore_checkpoint_column,
    output logic              restore_checkpoint_success
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [NUM_ARCH_REGS-1:0][PHYS_W-1:0] map_q;
    logic [NUM_PHYS_REGS-1:0]             ready_q;
    logic [NUM_ARCH_REGS-1:0][PHYS_W-1:0] ckpt_map_q [CHECKPOINT_COLUMNS];
    logic [ROB_W-1:0]                     ckpt_rob_q [CHECKPOINT_COLUMNS];
    logic [CHECKPOINT_COLUMNS-1:0]        ckpt_valid_q;
    logic [COL_W-1:0]                     tail_q;

    // ------------------------------------------------------------------
    // Request arbitration
    // ------------------------------------------------------------------
    logic do_restore;
    logic do_release;
    logic do_revert;
    logic do_rename;
    logic do_save;

    assign restore_checkpoint_success = restore_checkpoint_valid
                                      && ckpt_valid_q[restore_checkpoint_column]
                                      && (ckpt_rob_q[restore_checkpoint_column]
                                          == restore_checkpoint_ROB_index);

    assign do_restore = restore_checkpoint_success &&  restore_checkpoint_speculate_failed;
    assign do_release = restore_checkpoint_success && !restore_checkpoint_speculate_failed;
    assign do_revert  = revert_valid && !do_restore;
    assign do_rename  = rename_valid && !do_restore && !revert_valid;
    assign do_save    = save_checkpoint_valid && !do_restore && !revert_valid;

    // Map with this cycle's rename folded in; feeds both the map register
    // and a same-cycle checkpoint save.
    logic [NUM_ARCH_REGS-1:0][PHYS_W-1:0] map_renamed;

    always_comb begin
        map_renamed = map_q;
        if (do_rename) begin
            map_renamed[rename_dest_arch_reg_tag] = rename_dest_phys_reg_tag;
        end
    end

    // ------------------------------------------------------------------
    // Combinational outputs (start-of-cycle map)
    // ------------------------------------------------------------------
    // A same-cycle writeback counts as ready, unless a rename is handing out
    // that very tag this cycle (the tag is being recycled, the old value is
    // not the one the consumer wants).
    logic bypass_block;
    assign bypass_block = rename_valid && (rename_dest_phys_reg_tag == complete_phys_reg_tag);

    assign source_phys_reg_tag_A = map_q[source_arch_reg_tag_A];
    assign source_phys_reg_tag_B = map_q[source_arch_reg_tag_B];

    assign source_ready_A = ready_q[source_phys_reg_tag_A]
                          || (complete_valid && !bypass_block
                              && (complete_phys_reg_tag == source_phys_reg_tag_A));
    assign source_ready_B = ready_q[source_phys_reg_tag_B]
                          || (complete_valid && !bypass_block
                              && (complete_phys_reg_tag == source_phys_reg_tag_B));

    assign rename_old_dest_phys_reg_tag = map_q[rename_dest_arch_reg_tag];
    assign save_checkpoint_column       = tail_q;
    assign checkpoint_full              = ckpt_valid_q[tail_q];

    // ------------------------------------------------------------------
    // Sequential update
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < NUM_ARCH_REGS; i++) begin
                map_q[i] <= PHYS_W'(i);
            end
            ready_q      <= '1;
            ckpt_valid_q <= '0;
            tail_q       <= '0;
        end else begin
            // Ready bits: the rename clear is written last so it wins over
            // a complete on the same tag.
            if (complete_valid) begin
                ready_q[complete_phys_reg_tag] <= 1'b1;
            end
            if (do_rename) begin
                ready_q[rename_dest_phys_reg_tag] <= 1'b0;
            end

            if (do_restore) begin
                // Younger checkpoints are all on the wrong path; the restored
                // column stays live because its branch is still in flight
                // until the ROB retires it.
                map_q        <= ckpt_map_q[restore_checkpoint_column];
                tail_q       <= restore_checkpoint_column;
                ckpt_valid_q <= '0;
                ckpt_valid_q[restore_checkpoint_column] <= 1'b1;
            end else begin
                if (do_revert) begin
                    map_q[revert_dest_arch_reg_tag] <= revert_safe_dest_phys_reg_tag;
                end else begin
                    map_q <= map_renamed;
                end

                if (do_release) begin
                    ckpt_valid_q[restore_checkpoint_column] <= 1'b0;
                end

                // Save after release so an overwrite of the tail column
                // leaves it valid.
                if (do_save) begin
                    ckpt_valid_q[tail_q] <= 1'b1;
                    ckpt_rob_q[tail_q]   <= save_checkpoint_ROB_index;
                    ckpt_map_q[tail_q]   <= map_renamed;
                    tail_q               <= tail_q + COL_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_reg_map_table.sv
// Directed bench for reg_map_table. Inputs are driven 1ns after a rising
// edge, combinational outputs are sampled 1ns later, well before the next
// rising edge.
module tb_reg_map_table;

    logic       CLK;
    logic       RST;
    logic [4:0] source_arch_reg_tag_A;
    logic [5:0] source_phys_reg_tag_A;
    logic       source_ready_A;
    logic [4:0] source_arch_reg_tag_B;
    logic [5:0] source_phys_reg_tag_B;
    logic       source_ready_B;
    logic       rename_valid;
    logic [4:0] rename_dest_arch_reg_tag;
    logic [5:0] rename_dest_phys_reg_tag;
    logic [5:0] rename_old_dest_phys_reg_tag;
    logic       complete_valid;
    logic [5:0] complete_phys_reg_tag;
    logic       revert_valid;
    logic [4:0] revert_dest_arch_reg_tag;
    logic [5:0] revert_safe_dest_phys_reg_tag;
    logic       save_checkpoint_valid;
    logic [3:0] save_checkpoint_ROB_index;
    logic [1:0] save_checkpoint_column;
    logic       checkpoint_full;
    logic       restore_checkpoint_valid;
    logic       restore_checkpoint_speculate_failed;
    logic [3:0] restore_checkpoint_ROB_index;
    logic [1:0] restore_checkpoint_column;
    logic       restore_checkpoint_success;

    int tests_run;
    int tests_failed;

    reg_map_table dut (
        .CLK                                 (CLK),
        .RST                                 (RST),
        .source_arch_reg_tag_A               (source_arch_reg_tag_A),
        .source_phys_reg_tag_A               (source_phys_reg_tag_A),
        .source_ready_A                      (source_ready_A),
        .source_arch_reg_tag_B               (source_arch_reg_tag_B),
        .source_phys_reg_tag_B               (source_phys_reg_tag_B),
        .source_ready_B                      (source_ready_B),
        .rename_valid                        (rename_valid),
        .rename_dest_arch_reg_tag            (rename_dest_arch_reg_tag),
        .rename_dest_phys_reg_tag            (rename_dest_phys_reg_tag),
        .rename_old_dest_phys_reg_tag        (rename_old_dest_phys_reg_tag),
        .complete_valid                      (complete_valid),
        .complete_phys_reg_tag               (complete_phys_reg_tag),
        .revert_valid                        (revert_valid),
        .revert_dest_arch_reg_tag            (revert_dest_arch_reg_tag),
        .revert_safe_dest_phys_reg_tag       (revert_safe_dest_phys_reg_tag),
        .save_checkpoint_valid               (save_checkpoint_valid),
        .save_checkpoint_ROB_index           (save_checkpoint_ROB_index),
        .save_checkpoint_column              (save_checkpoint_column),
        .checkpoint_full                     (checkpoint_full),
        .restore_checkpoint_valid            (restore_checkpoint_valid),
        .restore_checkpoint_speculate_failed (restore_checkpoint_speculate_failed),
        .restore_checkpoint_ROB_index        (restore_checkpoint_ROB_index),
        .restore_checkpoint_column           (restore_checkpoint_column),
        .restore_checkpoint_success          (restore_checkpoint_success)
    );

    // ---------------- clock ----------------
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // ---------------- driver tasks ----------------
    task automatic idle();
        RST                                 = 1'b0;
        rename_valid                        = 1'b0;
        rename_dest_arch_reg_tag            = '0;
        rename_dest_phys_reg_tag            = '0;
        complete_valid                      = 1'b0;
        complete_phys_reg_tag               = '0;
        revert_valid                        = 1'b0;
        revert_dest_arch_reg_tag            = '0;
        revert_safe_dest_phys_reg_tag       = '0;
        save_checkpoint_valid               = 1'b0;
        save_checkpoint_ROB_index           = '0;
        restore_checkpoint_valid            = 1'b0;
        restore_checkpoint_speculate_failed = 1'b0;
        restore_checkpoint_ROB_index        = '0;
        restore_checkpoint_column           = '0;
    endtask

    // Advance one clock; inputs may change 1ns after the edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Let combinational outputs settle before sampling.
    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        idle();
        RST = 1'b1;
        tick();
        RST = 1'b0;
    endtask

    task automatic save(input logic [3:0] rob);
        save_checkpoint_valid     = 1'b1;
        save_checkpoint_ROB_index = rob;
    endtask

    task automatic restore(input logic [1:0] col, input logic [3:0] rob, input logic failed);
        restore_checkpoint_valid            = 1'b1;
        restore_checkpoint_column           = col;
        restore_checkpoint_ROB_index        = rob;
        restore_checkpoint_speculate_failed = failed;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        source_arch_reg_tag_A = 5'd5;
        source_arch_reg_tag_B = 5'd31;
        settle();
        tests_run++;
        if (source_phys_reg_tag_A !== 6'd5) begin
            tests_failed++;
            $display("FAIL reset_map_A: got %0d expected 5", source_phys_reg_tag_A);
        end
        tests_run++;
        if (source_ready_A !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_ready_A: got %0b expected 1", source_ready_A);
        end
        tests_run++;
        if (source_phys_reg_tag_B !== 6'd31 || source_ready_B !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_map_B: got %0d/%0b expected 31/1", source_phys_reg_tag_B, source_ready_B);
        end
        tests_run++;
        if (checkpoint_full !== 1'b0 || save_checkpoint_column !== 2'd0) begin
            tests_failed++;
            $display("FAIL reset_ckpt: got full=%0b col=%0d expected full=0 col=0", checkpoint_full, save_checkpoint_column);
        end
        tests_run++;
        if (restore_checkpoint_success !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_success: got %0b expected 0", restore_checkpoint_success);
        end
    endtask

    task automatic test_rename_complete();
        do_reset();
        source_arch_reg_tag_A    = 5'd3;
        rename_valid             = 1'b1;
        rename_dest_arch_reg_tag = 5'd3;
        rename_dest_phys_reg_tag = 6'd40;
        settle();
        tests_run++;
        if (rename_old_dest_phys_reg_tag !== 6'd3) begin
            tests_failed++;
            $display("FAIL rename_old_dest: got %0d expected 3", rename_old_dest_phys_reg_tag);
        end
        tests_run++;
        if (source_phys_reg_tag_A !== 6'd3) begin
            tests_failed++;
            $display("FAIL rename_not_visible_same_cycle: got %0d expected 3", source_phys_reg_tag_A);
        end
        tick();
        rename_valid = 1'b0;
        settle();
        tests_run++;
        if (source_phys_reg_tag_A !== 6'd40 || source_ready_A !== 1'b0) begin
            tests_failed++;
            $display("FAIL rename_applied: got %0d/%0b expected 40/0", source_phys_reg_tag_A, source_ready_A);
        end
        complete_valid        = 1'b1;
        complete_phys_reg_tag = 6'd40;
        settle();
        tests_run++;
        if (source_ready_A !== 1'b1) begin
            tests_failed++;
            $display("FAIL complete_bypass: got %0b expected 1", source_ready_A);
        end
        tick();
        complete_valid = 1'b0;
        settle();
        tests_run++;
        if (source_ready_A !== 1'b1) begin
            tests_failed++;
            $display("FAIL complete_sticky: got %0b expected 1", source_ready_A);
        end
        // Rename 9 -> 50 and complete 50 together: the clear wins.
        rename_valid             = 1'b1;
        rename_dest_arch_reg_tag = 5'd9;
        rename_dest_phys_reg_tag = 6'd50;
        complete_valid           = 1'b1;
        complete_phys_reg_tag    = 6'd50;
        tick();
        idle();
        source_arch_reg_tag_B = 5'd9;
        settle();
        tests_run++;
        if (source_phys_reg_tag_B !== 6'd50 || source_ready_B !== 1'b0) begin
            tests_failed++;
            $display("FAIL rename_clear_wins: got %0d/%0b expected 50/0", source_phys_reg_tag_B, source_ready_B);
        end
    endtask

    task automatic test_revert();
        // Map currently holds 3 -> 40 from the previous test.
        source_arch_reg_tag_A         = 5'd3;
        revert_valid                  = 1'b1;
        revert_dest_arch_reg_tag      = 5'd3;
        revert_safe_dest_phys_reg_tag = 6'd3;
        tick();
        idle();
        settle();
        tests_run++;
        if (source_phys_reg_tag_A !== 6'd3) begin
            tests_failed++;
            $display("FAIL revert_map: got %0d expected 3", source_phys_reg_tag_A);
        end
        // Revert arch 3 -> 33 alongside rename arch 6 -> 45: rename dropped.
        source_arch_reg_tag_B         = 5'd6;
        revert_valid                  = 1'b1;
        revert_dest_arch_reg_tag      = 5'd3;
        revert_safe_dest_phys_reg_tag = 6'd33;
        rename_valid                  = 1'b1;
        rename_dest_arch_reg_tag      = 5'd6;
        rename_dest_phys_reg_tag      = 6'd45;
        settle();
        tests_run++;
        if (rename_old_dest_phys_reg_tag !== 6'd6) begin
            tests_failed++;
            $display("FAIL revert_old_dest_driven: got %0d expected 6", rename_old_dest_phys_reg_tag);
        end
        tick();
        idle();
        settle();
        tests_run++;
        if (source_phys_reg_tag_B !== 6'd6) begin
            tests_failed++;
            $display("FAIL revert_drops_rename: got %0d expected 6", source_phys_reg_tag_B);
        end
        tests_run++;
        if (source_phys_reg_tag_A !== 6'd33 || source_ready_A !== 1'b1) begin
            tests_failed++;
            $display("FAIL revert_applied: got %0d/%0b expected 33/1", source_phys_reg_tag_A, source_ready_A);
        end
    endtask

    task automatic test_checkpoint_restore();
        do_reset();
        source_arch_reg_tag_A = 5'd4;
        source_arch_reg_tag_B = 5'd8;
        save(4'd7);
        settle();
        tests_run++;
        if (save_checkpoint_column !== 2'd0) begin
            tests_failed++;
            $display("FAIL save_col0: got %0d expected 0", save_checkpoint_column);
        end
        tick();
        idle();
        rename_valid             = 1'b1;
        rename_dest_arch_reg_tag = 5'd4;
        rename_dest_phys_reg_tag = 6'd41;
        tick();
        idle();
        save(4'd9);
        settle();
        tests_run++;
        if (save_checkpoint_column !== 2'd1 || source_phys_reg_tag_A !== 6'd41) begin
            tests_failed++;
            $display("FAIL save_col1: got col=%0d map4=%0d expected col=1 map4=41", save_checkpoint_column, source_phys_reg_tag_A);
        end
        tick();
        idle();
        // Mispredict at column 0 with a rename and save in the same cycle.
        restore(2'd0, 4'd7, 1'b1);
        rename_valid             = 1'b1;
        rename_dest_arch_reg_tag = 5'd8;
        rename_dest_phys_reg_tag = 6'd55;
        save(4'd3);
        settle();
        tests_run++;
        if (restore_checkpoint_success !== 1'b1) begin
            tests_failed++;
            $display("FAIL restore_success: got %0b expected 1", restore_checkpoint_success);
        end
        tick();
        idle();
        settle();
        tests_run++;
        if (source_phys_reg_tag_A !== 6'd4 || source_phys_reg_tag_B !== 6'd8) begin
            tests_failed++;
            $display("FAIL restore_map: got map4=%0d map8=%0d expected 4/8", source_phys_reg_tag_A, source_phys_reg_tag_B);
        end
        tests_run++;
        if (save_checkpoint_column !== 2'd0 || checkpoint_full !== 1'b1) begin
            tests_failed++;
            $display("FAIL restore_tail: got col=%0d full=%0b expected col=0 full=1", save_checkpoint_column, checkpoint_full);
        end
        restore(2'd1, 4'd9, 1'b0);
        settle();
        tests_run++;
        if (restore_checkpoint_success !== 1'b0) begin
            tests_failed++;
            $display("FAIL restore_col1_invalid: got %0b expected 0", restore_checkpoint_success);
        end
        tick();
        idle();
    endtask

    task automatic test_release();
        do_reset();
        source_arch_reg_tag_A = 5'd4;
        save(4'd2);
        tick();
        save(4'd9);
        rename_valid             = 1'b1;
        rename_dest_arch_reg_tag = 5'd4;
        rename_dest_phys_reg_tag = 6'd41;
        tick();
        idle();
        restore(2'd1, 4'd5, 1'b1);
        settle();
        tests_run++;
        if (restore_checkpoint_success !== 1'b0) begin
            tests_failed++;
            $display("FAIL restore_rob_mismatch: got %0b expected 0", restore_checkpoint_success);
        end
        tick();
        idle();
        settle();
        tests_run++;
        if (source_phys_reg_tag_A !== 6'd41 || save_checkpoint_column !== 2'd2) begin
            tests_failed++;
            $display("FAIL mismatch_no_change: got map4=%0d col=%0d expected 41/2", source_phys_reg_tag_A, save_checkpoint_column);
        end
        restore(2'd1, 4'd9, 1'b0);
        settle();
        tests_run++;
        if (restore_checkpoint_success !== 1'b1) begin
            tests_failed++;
            $display("FAIL release_success: got %0b expected 1", restore_checkpoint_success);
        end
        tick();
        idle();
        restore(2'd1, 4'd9, 1'b0);
        settle();
        tests_run++;
        if (restore_checkpoint_success !== 1'b0 || source_phys_reg_tag_A !== 6'd41 || save_checkpoint_column !== 2'd2) begin
            tests_failed++;
            $display("FAIL release_effect: got succ=%0b map4=%0d col=%0d expected 0/41/2", restore_checkpoint_success, source_phys_reg_tag_A, save_checkpoint_column);
        end
        // Column 0 must still be live.
        restore(2'd0, 4'd2, 1'b0);
        settle();
        tests_run++;
        if (restore_checkpoint_success !== 1'b1) begin
            tests_failed++;
            $display("FAIL release_other_intact: got %0b expected 1", restore_checkpoint_success);
        end
        tick();
        idle();
    endtask

    task automatic test_full_wrap();
        do_reset();
        source_arch_reg_tag_A = 5'd5;
        for (int i = 0; i < 4; i++) begin
            save(4'(i));
            tick();
        end
        idle();
        settle();
        tests_run++;
        if (checkpoint_full !== 1'b1 || save_checkpoint_column !== 2'd0) begin
            tests_failed++;
            $display("FAIL full_after_four: got full=%0b col=%0d expected 1/0", checkpoint_full, save_checkpoint_column);
        end
        // Fifth save overwrites column 0, capturing a same-cycle rename.
        save(4'd12);
        rename_valid             = 1'b1;
        rename_dest_arch_reg_tag = 5'd5;
        rename_dest_phys_reg_tag = 6'd50;
        tick();
        idle();
        restore(2'd0, 4'd0, 1'b0);
        settle();
        tests_run++;
        if (restore_checkpoint_success !== 1'b0 || save_checkpoint_column !== 2'd1 || checkpoint_full !== 1'b1) begin
            tests_failed++;
            $display("FAIL overwrite_col0: got succ=%0b col=%0d full=%0b expected 0/1/1", restore_checkpoint_success, save_checkpoint_column, checkpoint_full);
        end
        // Put arch 5 elsewhere, then restore the overwritten column.
        idle();
        rename_valid             = 1'b1;
        rename_dest_arch_reg_tag = 5'd5;
        rename_dest_phys_reg_tag = 6'd60;
        tick();
        idle();
        restore(2'd0, 4'd12, 1'b1);
        tick();
        idle();
        settle();
        tests_run++;
        if (source_phys_reg_tag_A !== 6'd50 || save_checkpoint_column !== 2'd0) begin
            tests_failed++;
            $display("FAIL overwrite_restore: got map5=%0d col=%0d expected 50/0", source_phys_reg_tag_A, save_checkpoint_column);
        end
    endtask

    task automatic test_reset_mid();
        idle();
        source_arch_reg_tag_A = 5'd7;
        rename_valid             = 1'b1;
        rename_dest_arch_reg_tag = 5'd7;
        rename_dest_phys_reg_tag = 6'd61;
        save(4'd4);
        tick();
        // Reset with more requests pending: everything is ignored.
        RST                      = 1'b1;
        rename_valid             = 1'b1;
        rename_dest_arch_reg_tag = 5'd7;
        rename_dest_phys_reg_tag = 6'd62;
        save(4'd5);
        tick();
        idle();
        settle();
        tests_run++;
        if (source_phys_reg_tag_A !== 6'd7 || source_ready_A !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_reset_map: got %0d/%0b expected 7/1", source_phys_reg_tag_A, source_ready_A);
        end
        tests_run++;
        if (checkpoint_full !== 1'b0 || save_checkpoint_column !== 2'd0) begin
            tests_failed++;
            $display("FAIL mid_reset_ckpt: got full=%0b col=%0d expected 0/0", checkpoint_full, save_checkpoint_column);
        end
        restore(2'd0, 4'd0, 1'b0);
        settle();
        tests_run++;
        if (restore_checkpoint_success !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_reset_cols_invalid: got %0b expected 0", restore_checkpoint_success);
        end
        idle();
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        tests_run             = 0;
        tests_failed          = 0;
        source_arch_reg_tag_A = '0;
        source_arch_reg_tag_B = '0;
        idle();
        test_reset();
        test_rename_complete();
        test_revert();
        test_checkpoint_restore();
        test_release();
        test_full_wrap();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/reg_map_table.md
Name: reg_map_table

Overview:
- Architectural-to-physical register map table for the OoO rename stage; sits directly downstream of the physical register free list.
- Consumes the free list's dequeued phys reg tag to rename a dispatching instruction's destination, and returns the old mapping for the ROB to free at commit.
- Supports single-step revert from ROB rollback, and checkpoint save/restore of the whole map for branch speculation.
- Tracks a per-phys-reg ready bit for source operand readiness.

Parameters:
- NUM_ARCH_REGS, 32, architectural registers; arch tag width = log2 = 5.
- NUM_PHYS_REGS, 64, physical registers; phys tag width = log2 = 6.
- CHECKPOINT_COLUMNS, 4, map checkpoint slots; column width = log2 = 2.
- ROB_DEPTH, 16, ROB entries; ROB index width = 4.

Ports:
- CLK  in  1  clock.
- RST  in  1  reset; synchronous, active-high.
- source_arch_reg_tag_A  in  5  source A arch reg.
- source_phys_reg_tag_A  out  6  current mapping of source A.
- source_ready_A  out  1  ready bit of source_phys_reg_tag_A.
- source_arch_reg_tag_B  in  5  source B arch reg.
- source_phys_reg_tag_B  out  6  current mapping of source B.
- source_ready_B  out  1  ready bit of source_phys_reg_tag_B.
- rename_valid  in  1  rename the destination this cycle.
- rename_dest_arch_reg_tag  in  5  destination arch reg.
- rename_dest_phys_reg_tag  in  6  new phys reg, from the free list dequeue.
- rename_old_dest_phys_reg_tag  out  6  previous mapping of the destination, to the ROB.
- complete_valid  in  1  writeback of a phys reg.
- complete_phys_reg_tag  in  6  phys reg written.
- revert_valid  in  1  ROB rollback of one mapping.
- revert_dest_arch_reg_tag  in  5  arch reg to revert.
- revert_safe_dest_phys_reg_tag  in  6  mapping to reinstall.
- save_checkpoint_valid  in  1  save map checkpoint.
- save_checkpoint_ROB_index  in  4  ROB index of the saving branch.
- save_checkpoint_column  out  2  column that will be or was written (tail).
- checkpoint_full  out  1  tail column currently valid.
- restore_checkpoint_valid  in  1  branch resolved.
- restore_checkpoint_speculate_failed  in  1  1 = mispredict (restore), 0 = correct (release).
- restore_checkpoint_ROB_index  in  4  tag check value.
- restore_checkpoint_column  in  2  column to restore or release.
- restore_checkpoint_success  out  1  column valid and ROB index matched.

Behaviour:
- Reset (RST high at a posedge): map[i] = i for all arch regs; ready[p] = 1 for all p; all checkpoint columns invalid; tail = 0.
- Outputs after reset (combinational from state):
  - source_phys_reg_tag_A/B = source_arch_reg_tag_A/B; source_ready_A/B = 1.
  - rename_old_dest_phys_reg_tag = map[rename_dest_arch_reg_tag].
  - save_checkpoint_column = 0; checkpoint_full = 0; restore_checkpoint_success = 0 unless restore_checkpoint_valid is high.
- Source reads are combinational from the start-of-cycle map; a same-cycle rename is not visible to them.
- source_ready_X = ready[tag] OR (complete_valid AND complete_phys_reg_tag == tag). This same-cycle complete bypass is exempt when a same-cycle rename targets that tag (see next item).
- Rename:
  - rename_old_dest_phys_reg_tag = map[dest] combinationally.
  - Next cycle: map[dest] = new tag and ready[new tag] = 0.
  - If complete hits the same tag in the same cycle, the rename clear wins.
- Complete: ready[tag] = 1 next cycle.
- Revert: map[arch] = safe tag next cycle. Ready bits are unchanged.
- Save:
  - Column[tail] captures {valid = 1, ROB_index, map}, with any same-cycle rename write applied.
  - tail = tail + 1, mod CHECKPOINT_COLUMNS.
  - If checkpoint_full, the save overwrites the column anyway; dispatch stalls on checkpoint_full.
- Restore:
  - success = column valid AND stored ROB_index == restore_checkpoint_ROB_index.
  - Success with failed = 1: map = column map; tail = restore column; all other columns invalid; the restore column stays valid.
  - Success with failed = 0: invalidate that column only. Map and tail are unchanged.
  - Mismatch: no state change; success = 0.
- Priority when several requests arrive in one cycle:
  - Failed restore overrides revert, rename, save and release; any rename or save in that cycle is dropped.
  - Otherwise revert overrides rename and save; the rename is dropped and old_dest is still driven.
  - Otherwise rename and save together are legal.
  - A release (failed = 0) may coincide with any of the above.
  - Complete is always applied.
- Reset mid-operation: RST overrides every input in that cycle.

Test Plan:
- Reset -> source A = 5 reads phys 5, ready 1; checkpoint_full 0; save_checkpoint_column 0.
- Rename arch 3 -> phys 40 -> old_dest = 3 that cycle. Next cycle source 3 reads 40 with ready 0. complete 40 in the following cycle -> source_ready_A = 1 same cycle via bypass, and ready stays 1 afterwards.
- Rename arch 3 -> 40, then revert arch 3 with safe tag 3 -> source 3 reads 3. Revert and rename in the same cycle -> rename dropped.
- Save at ROB 7 (column 0), rename arch 4 -> 41, save at ROB 9 (column 1), then restore column 0 with ROB 7 and failed = 1 -> success 1; arch 4 maps to 4; column 1 invalid; tail = 0.
- Restore column 1 with ROB 5 when ROB 9 is stored -> success 0, no change. Restore column 1 with ROB 9, failed = 0 -> success 1; column 1 invalid; map unchanged.
- Four saves -> checkpoint_full 1 with tail wrapped to 0. A fifth save overwrites column 0. Assert RST mid-sequence -> all state returns to reset values.
